sodor_stim_stage: RTL
=====================

# sodor_stim_stage

Parametrised stimulus staging block for the Sodor fuzz harness top level. It sits between the harness input pins and the `Core` instance. It delays every stimulus channel by a configurable number of register stages and generates a stretched, software-retriggerable core reset. It also provides a cycle counter that measures the time since the core left reset. The optional stall-injection mode freezes the stimulus pipeline.

## Interface
Parameters:
- `DATA_W`, 32, width of the data channels (`SIZE_OF_THE_BUS`).
- `ADDR_W`, 5, width of the debug-datapath address.
- `STAGES`, 1, register stages on every stimulus channel; legal range 1..8.
- `RST_HOLD`, 4, number of cycles the core reset is held after release or retrigger; legal range 1..255.
- `CNT_W`, 32, width of the cycle counter.

Ports:
- `clock`  in  1  the single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `soft_reset`  in  1  synchronous core-reset retrigger request.
- `hold`  in  1  stall request; present only with `SODOR_STIM_HOLD_EN`.
- `ddpath_addr`  in  ADDR_W  raw debug-datapath address.
- `ddpath_wdata`  in  DATA_W  raw debug-datapath write data.
- `dmem_resp_data`  in  DATA_W  raw data-memory response data.
- `dmem_resp_valid`  in  1  raw data-memory response valid.
- `imem_resp_data`  in  DATA_W  raw instruction-memory response data.
- `core_reset`  out  1  stretched reset driven to `Core.reset`.
- `s_ddpath_addr`, `s_ddpath_wdata`, `s_dmem_resp_data`, `s_dmem_resp_valid`, `s_imem_resp_data`  out  as inputs  staged copies of the five stimulus inputs.
- `run_cycles`  out  CNT_W  number of cycles since `core_reset` last fell; saturates.

## Operation
- Reset sequencer has two states, HOLD and RUN, and an 8-bit down-counter `hcnt`.
- `reset` asserted (asynchronous): state becomes HOLD and `hcnt` becomes RST_HOLD.
  - All stage registers and `run_cycles` clear to 0.
  - `core_reset` goes to 1.
- HOLD:
  - `core_reset` = 1.
  - Each edge decrements `hcnt`.
  - On the edge where `hcnt` = 1, the state moves to RUN.
- RUN:
  - `core_reset` = 0.
  - `soft_reset` = 1 at an edge moves the state to HOLD and reloads `hcnt` to RST_HOLD.
- `soft_reset` = 1 while already in HOLD reloads `hcnt` to RST_HOLD, which extends the hold. It never shortens it.
- Stage pipeline: each channel is a STAGES-deep shift register and loads every edge, including during HOLD. This gives the core settled stimulus when it leaves reset.
- `s_dmem_resp_valid` is the staged valid ANDed with `!core_reset`. It is never 1 while the core is in reset.
- `run_cycles`:
  - Forced to 0 while `core_reset` = 1.
  - Increments by 1 each RUN edge.
  - Holds at 2^CNT_W−1 (no wrap).

## Timing
- Reset values: `core_reset` = 1; all `s_*` outputs = 0; `run_cycles` = 0.
- Stimulus latency: an input sampled at edge t appears on `s_*` after edge t+STAGES−1. With STAGES=1 this matches the single-register behaviour of the existing harness.
- `core_reset` falls on the RST_HOLD-th rising edge after `reset` deasserts, so it is high for exactly RST_HOLD full cycles.
- `soft_reset` sampled at edge t: `core_reset` = 1 after edge t and stays 1 for RST_HOLD cycles.
- `reset` asserted mid-RUN or mid-HOLD: asynchronous return to reset values. The stall state is ignored.
- `soft_reset` and `hold` on the same edge: the retrigger takes effect; the pipeline freezes as described under Configuration.

## Configuration
- `SODOR_STIM_HOLD_EN` defined:
  - The `hold` port exists.
  - When `hold` = 1 at an edge, all stage registers keep their value.
  - `s_dmem_resp_valid` is forced to 0 during every cycle `hold` = 1, so no response is duplicated.
  - `run_cycles` still counts.
  - `hcnt` still counts.
- Macro undefined: the port is absent and the pipeline loads every cycle.

## Structure
- Package `sodor_stim_pkg` holds:
  - the state enum (`ST_HOLD`, `ST_RUN`);
  - the `SODOR_BUS_W` default of 32;
  - `HCNT_W` = 8.
- Sub-module `stim_pipe`: a generic WIDTH × STAGES delay line with an enable and asynchronous clear. It is instantiated once per channel, five times in total.

## Test plan
- RST_HOLD=4: deassert `reset` → `core_reset` is 1 for 4 edges, falls on the 4th; `run_cycles` reads 1 one edge later.
- STAGES=3: drive `imem_resp_data` = 0xDEADBEEF for one cycle at edge t → `s_imem_resp_data` = 0xDEADBEEF after edge t+2 only.
- `soft_reset` pulse in RUN with `run_cycles` = 10 → `run_cycles` = 0 and `core_reset` = 1 for 4 cycles, then counting restarts at 1.
- `dmem_resp_valid` = 1 held constant from `reset` release → `s_dmem_resp_valid` = 0 until `core_reset` falls, then 1.
- CNT_W=4, run 20 cycles → `run_cycles` saturates at 15.
- With `SODOR_STIM_HOLD_EN`: `hold` = 1 for 3 cycles while the data ramps 1,2,3 → `s_*` frozen at the pre-hold value and `s_dmem_resp_valid` = 0; after `hold` drops, the ramp resumes with STAGES latency.

Source files
------------

// File: rtl/sodor_stim_pkg.sv
// Shared types and constants for the Sodor fuzz-harness stimulus stage.
// The SODOR_STIM_HOLD_EN build option is handled in sodor_stim_stage.
package sodor_stim_pkg;

   localparam int SODOR_BUS_W = 32;
   localparam int HCNT_W      = 8;

   typedef enum logic {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } stim_state_e;

endpackage

// File: rtl/sodor_stim_pipe.sv
// Generic WIDTH x STAGES delay line with load enable and async clear.
// The output is the oldest stage.
module stim_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] stage_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_q <= '0;
      end else if (en_i) begin
         for (int i = STAGES - 1; i > 0; i--) begin
            stage_q[i] <= stage_q[i-1];
         end
         stage_q[0] <= d_i;
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sodor_stim_stage.sv
// Stimulus staging and stretched core reset for the Sodor harness.
// Define SODOR_STIM_HOLD_EN to add the hold (pipeline stall) input.
module sodor_stim_stage
   import sodor_stim_pkg::*;
#(
   parameter int DATA_W   = SODOR_BUS_W,
   parameter int ADDR_W   = 5,
   parameter int STAGES   = 1,
   parameter int RST_HOLD = 4,
   parameter int CNT_W    = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              soft_reset,
`ifdef SODOR_STIM_HOLD_EN
   input  logic              hold,
`endif
   input  logic [ADDR_W-1:0] ddpath_addr,
   input  logic [DATA_W-1:0] ddpath_wdata,
   input  logic [DATA_W-1:0] dmem_resp_data,
   input  logic              dmem_resp_valid,
   input  logic [DATA_W-1:0] imem_resp_data,
   output logic              core_reset,
   output logic [ADDR_W-1:0] s_ddpath_addr,
   output logic [DATA_W-1:0] s_ddpath_wdata,
   output logic [DATA_W-1:0] s_dmem_resp_data,
   output logic              s_dmem_resp_valid,
   output logic [DATA_W-1:0] s_imem_resp_data,
   output logic [CNT_W-1:0]  run_cycles
);

   localparam logic [HCNT_W-1:0] HOLD_LD = HCNT_W'(RST_HOLD);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   stim_state_e       state_q;
   logic [HCNT_W-1:0] hcnt_q;
   logic              core_rst_q;
   logic [CNT_W-1:0]  run_q;
   logic [CNT_W-1:0]  run_d;
   logic              pipe_en;
   logic              stall;
   logic              valid_st;

`ifdef SODOR_STIM_HOLD_EN
   assign stall = hold;
`else
   assign stall = 1'b0;
`endif

   assign pipe_en = !stall;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_HOLD;
         hcnt_q     <= HOLD_LD;
         core_rst_q <= 1'b1;
      end else begin
         unique case (state_q)
            ST_HOLD: begin
               if (soft_reset) begin
                  hcnt_q <= HOLD_LD;
               end else begin
                  hcnt_q <= hcnt_q - 1'b1;
                  if (hcnt_q == HCNT_W'(1)) begin
                     state_q    <= ST_RUN;
                     core_rst_q <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (soft_reset) begin
                  state_q    <= ST_HOLD;
                  hcnt_q     <= HOLD_LD;
                  core_rst_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= ST_HOLD;
               hcnt_q     <= HOLD_LD;
               core_rst_q <= 1'b1;
            end
         endcase
      end
   end

   // Counter clears on the same edge that re-enters HOLD.
   always_comb begin
      run_d = '0;
      if (state_q == ST_RUN && !soft_reset) begin
         run_d = (run_q == CNT_MAX) ? run_q : run_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end

   stim_pipe #(.WIDTH(ADDR_W), .STAGES(STAGES)) u_addr (
      .clock (clock),
      .reset (reset),
      .en_i  (pipe_en),
      .d_i   (ddpath_addr),
      .q_o   (s_ddpath_addr)
   );

   stim_pipe #(.WIDTH(DATA_W), .STAGES(STAGES)) u_wdata (
      .clock (clock),
      .reset (reset),
      .en_i  (pipe_en),
      .d_i   (ddpath_wdata),
      .q_o   (s_ddpath_wdata)
   );

   stim_pipe #(.WIDTH(DATA_W), .STAGES(STAGES)) u_dmem (
      .clock (clock),
      .reset (reset),
      .en_i  (pipe_en),
      .d_i   (dmem_resp_data),
      .q_o   (s_dmem_resp_data)
   );

   stim_pipe #(.WIDTH(1), .STAGES(STAGES)) u_valid (
      .clock (clock),
      .reset (reset),
      .en_i  (pipe_en),
      .d_i   (dmem_resp_valid),
      .q_o   (valid_st)
   );

   stim_pipe #(.WIDTH(DATA_W), .STAGES(STAGES)) u_imem (
      .clock (clock),
      .reset (reset),
      .en_i  (pipe_en),
      .d_i   (imem_resp_data),
      .q_o   (s_imem_resp_data)
   );

   assign core_reset        = core_rst_q;
   assign run_cycles        = run_q;
   assign s_dmem_resp_valid = valid_st && !core_rst_q && !stall;

endmodule
